// File: rtl/palette_ram_banked.sv
// palette_ram_banked: multi-bank runtime-loadable colour palette, 2-cycle read latency.
// Each bank is its own RAM so the default load can fill every bank in parallel.
module palette_ram_banked #(
  parameter int IDX_W = 4,
  parameter int CH_W = 4,
  parameter int BANKS = 4,
  parameter int TRANSP_IDX = 0,
  localparam int BK_W = $clog2(BANKS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_valid,
  input  logic [BK_W-1:0]   rd_bank,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic              transp_en,
  input  logic [1:0]        dim,
  input  logic              wr_en,
  input  logic [BK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_data,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              transparent,
  output logic              init_busy
);
  localparam int DW = 3 * CH_W;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] def_ch;
  logic [IDX_W-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] bank_rd [BANKS];
  logic [DW-1:0] sel;
  logic [BK_W-1:0] bk1_q;
  logic v1_q, k1_q;
  logic [1:0] d1_q;
  logic [DW-1:0] rgb_q, rgb_d;
  logic out_valid_q, transp_q;
  always_comb begin
    state_d = (state_q == INIT && cnt_q == '1) ? RUN : state_q;
    cnt_d = (state_q == INIT) ? cnt_q + IDX_W'(1) : cnt_q;
    def_ch = CH_W'(cnt_q);
    wa = (state_q == INIT) ? cnt_q : wr_index;
    wd = (state_q == INIT) ? {def_ch, def_ch, def_ch} : wr_data;
    sel = bank_rd[bk1_q];
    rgb_d = v1_q ? {sel[DW-1 -: CH_W] >> d1_q, sel[2*CH_W-1 -: CH_W] >> d1_q, sel[CH_W-1:0] >> d1_q} : rgb_q;
  end
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DW-1:0] mem [2**IDX_W];
    logic [DW-1:0] rd_q;
    // Read samples before the write lands, so same-cycle collisions return old data.
    always_ff @(posedge Clk) begin
      if (!Reset && (state_q == INIT || (wr_en && wr_bank == BK_W'(b)))) mem[wa] <= wd;
      rd_q <= mem[rd_index];
    end
    assign bank_rd[b] = rd_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      v1_q <= 1'b0;
      k1_q <= 1'b0;
      d1_q <= '0;
      bk1_q <= '0;
      rgb_q <= '0;
      out_valid_q <= 1'b0;
      transp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      v1_q <= rd_valid && state_q == RUN;
      k1_q <= transp_en && rd_index == IDX_W'(TRANSP_IDX);
      d1_q <= dim;
      bk1_q <= rd_bank;
      rgb_q <= rgb_d;
      out_valid_q <= v1_q;
      transp_q <= k1_q && v1_q;
    end
  end
  assign {red, green, blue} = rgb_q;
  assign out_valid = out_valid_q;
  assign transparent = transp_q;
  assign init_busy = state_q == INIT;
endmodule

// File: tb/tb_palette_ram_banked.sv
// tb_palette_ram_banked: directed scenarios plus randomized traffic against a palette model.
module tb_palette_ram_banked;
  logic Clk = 1'b0;
  logic Reset, rd_valid, transp_en, wr_en;
  logic [1:0] rd_bank, wr_bank, dim;
  logic [3:0] rd_index, wr_index;
  logic [11:0] wr_data;
  logic [3:0] red, green, blue;
  logic out_valid, transparent, init_busy;
  logic [11:0] rgb_o;
  int checks = 0;
  int errors = 0;

  palette_ram_banked dut (
    .Clk(Clk), .Reset(Reset), .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_index(rd_index),
    .transp_en(transp_en), .dim(dim), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_data(wr_data), .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .transparent(transparent), .init_busy(init_busy)
  );

  always #5 Clk = ~Clk;
  assign rgb_o = {red, green, blue};

  typedef struct {bit v; logic [11:0] rgb; bit t;} rec_t;
  logic [11:0] m [4][16];
  rec_t pend;
  int busy_n = 16;
  bit e_v, e_t;
  logic [11:0] e_rgb;

  function automatic logic [11:0] dimmed(input logic [11:0] c, input logic [1:0] d);
    logic [3:0] r, g, b;
    r = c[11:8] >> d;
    g = c[7:4] >> d;
    b = c[3:0] >> d;
    return {r, g, b};
  endfunction

  // Advance one clock; the model sees the same inputs the DUT sampled at that edge.
  task automatic tick();
    rec_t n;
    logic [3:0] c;
    @(posedge Clk);
    if (Reset) begin
      pend = '{v: 1'b0, rgb: 12'h0, t: 1'b0};
      e_v = 1'b0;
      e_t = 1'b0;
      e_rgb = 12'h0;
      busy_n = 16;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 16; i++) begin
          c = 4'(i);
          m[b][i] = {c, c, c};
        end
    end else begin
      n.v = rd_valid && busy_n == 0;
      n.rgb = dimmed(m[rd_bank][rd_index], dim);
      n.t = n.v && transp_en && rd_index == 4'd0;
      e_v = pend.v;
      e_t = pend.t;
      if (pend.v) e_rgb = pend.rgb;
      pend = n;
      if (busy_n == 0 && wr_en) m[wr_bank][wr_index] = wr_data;
      if (busy_n > 0) busy_n--;
    end
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; rd_valid = 1'b0; wr_en = 1'b0; transp_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] b, input logic [3:0] i, input logic [1:0] d);
    rd_valid = 1'b1; rd_bank = b; rd_index = i; dim = d;
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] v);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_data = v;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (rgb_o !== 12'h0) begin errors++; $display("FAIL reset_rgb got %h exp %h", rgb_o, 12'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (transparent !== 1'b0) begin errors++; $display("FAIL reset_transp got %b exp 0", transparent); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", init_busy); end
    for (int i = 1; i <= 16; i++) begin
      rd(2'd2, 4'd9, 2'd0);
      wr(2'd2, 4'd9, 12'($urandom));
      tick();
      checks++; if (init_busy !== (i < 16)) begin errors++; $display("FAIL init_busy cyc %0d got %b exp %b", i, init_busy, i < 16); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_valid cyc %0d got %b exp 0", i, out_valid); end
    end
    idle();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_last_read got %b exp 0", out_valid); end
  endtask

  task automatic test_default_read();
    rd(2'd2, 4'd9, 2'd0);
    tick();
    idle();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dflt_valid got %b exp 1", out_valid); end
    checks++; if (rgb_o !== 12'h999 || rgb_o !== e_rgb) begin errors++; $display("FAIL dflt_rgb got %h exp %h", rgb_o, 12'h999); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dflt_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_write_read();
    wr(2'd1, 4'd3, 12'hE22);
    tick();
    idle();
    rd(2'd1, 4'd3, 2'd0);
    tick();
    rd(2'd0, 4'd3, 2'd0);
    tick();
    checks++; if (out_valid !== 1'b1 || rgb_o !== 12'hE22) begin errors++; $display("FAIL wr_rd got %b/%h exp 1/%h", out_valid, rgb_o, 12'hE22); end
    idle();
    tick();
    checks++; if (out_valid !== 1'b1 || rgb_o !== 12'h333) begin errors++; $display("FAIL bank_indep got %b/%h exp 1/%h", out_valid, rgb_o, 12'h333); end
  endtask

  task automatic test_rdw();
    wr(2'd0, 4'd5, 12'hA60);
    rd(2'd0, 4'd5, 2'd0);
    tick();
    idle();
    rd(2'd0, 4'd5, 2'd0);
    tick();
    checks++; if (rgb_o !== 12'h555) begin errors++; $display("FAIL rdw_old got %h exp %h", rgb_o, 12'h555); end
    idle();
    tick();
    checks++; if (rgb_o !== 12'hA60) begin errors++; $display("FAIL rdw_new got %h exp %h", rgb_o, 12'hA60); end
  endtask

  task automatic test_transp();
    wr(2'd0, 4'd0, 12'h123);
    tick();
    idle();
    transp_en = 1'b1;
    rd(2'd0, 4'd0, 2'd0);
    tick();
    rd(2'd0, 4'd1, 2'd0);
    tick();
    checks++; if (out_valid !== 1'b1 || transparent !== 1'b1 || rgb_o !== 12'h123) begin errors++; $display("FAIL transp_key got %b/%b/%h exp 1/1/123", out_valid, transparent, rgb_o); end
    transp_en = 1'b0;
    rd(2'd0, 4'd0, 2'd0);
    tick();
    checks++; if (out_valid !== 1'b1 || transparent !== 1'b0) begin errors++; $display("FAIL transp_idx1 got %b/%b exp 1/0", out_valid, transparent); end
    idle();
    tick();
    checks++; if (out_valid !== 1'b1 || transparent !== 1'b0) begin errors++; $display("FAIL transp_off got %b/%b exp 1/0", out_valid, transparent); end
  endtask

  task automatic test_dim();
    wr(2'd3, 4'd7, 12'hCA8);
    tick();
    idle();
    rd(2'd3, 4'd7, 2'd1);
    tick();
    rd(2'd3, 4'd7, 2'd3);
    tick();
    checks++; if (rgb_o !== 12'h654) begin errors++; $display("FAIL dim1 got %h exp %h", rgb_o, 12'h654); end
    rd(2'd3, 4'd7, 2'd0);
    tick();
    checks++; if (rgb_o !== 12'h111) begin errors++; $display("FAIL dim3 got %h exp %h", rgb_o, 12'h111); end
    idle();
    dim = 2'd2;
    tick();
    checks++; if (rgb_o !== 12'hCA8) begin errors++; $display("FAIL dim_late got %h exp %h", rgb_o, 12'hCA8); end
    tick();
    checks++; if (out_valid !== 1'b0 || rgb_o !== 12'hCA8) begin errors++; $display("FAIL hold got %b/%h exp 0/%h", out_valid, rgb_o, 12'hCA8); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Reset = 1'b0;
      rd_valid = $urandom_range(0, 3) != 0;
      rd_bank = 2'($urandom);
      rd_index = 4'($urandom_range(0, 3));
      transp_en = 1'($urandom);
      dim = 2'($urandom);
      wr_en = 1'($urandom);
      wr_bank = 2'($urandom);
      wr_index = 4'($urandom_range(0, 3));
      wr_data = 12'($urandom);
      tick();
      checks++;
      if (out_valid !== e_v || transparent !== e_t || rgb_o !== e_rgb || init_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand cyc %0d got v%b t%b %h exp v%b t%b %h", n, out_valid, transparent, rgb_o, e_v, e_t, e_rgb);
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    wr(2'd1, 4'd3, 12'h7BD);
    tick();
    idle();
    rd(2'd1, 4'd3, 2'd0);
    tick();
    rd(2'd1, 4'd3, 2'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || init_busy !== 1'b1) begin errors++; $display("FAIL mid_reset got v%b busy%b exp v0 busy1", out_valid, init_busy); end
    for (int i = 1; i <= 16; i++) begin
      rd(2'd1, 4'd3, 2'd0);
      wr(2'd1, 4'd3, 12'hFFF);
      tick();
      checks++; if (init_busy !== (i < 16) || out_valid !== 1'b0) begin errors++; $display("FAIL mid_init cyc %0d got busy%b v%b exp busy%b v0", i, init_busy, out_valid, i < 16); end
    end
    idle();
    rd(2'd1, 4'd3, 2'd0);
    tick();
    idle();
    tick();
    checks++; if (out_valid !== 1'b1 || rgb_o !== 12'h333 || rgb_o !== e_rgb) begin errors++; $display("FAIL mid_default got %b/%h exp 1/%h", out_valid, rgb_o, 12'h333); end
  endtask

  initial begin
    Reset = 1'b0; rd_valid = 1'b0; rd_bank = '0; rd_index = '0; transp_en = 1'b0; dim = '0;
    wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_data = '0;
    pend = '{v: 1'b0, rgb: 12'h0, t: 1'b0};
    e_v = 1'b0; e_t = 1'b0; e_rgb = 12'h0;
    test_reset();
    test_default_read();
    test_write_read();
    test_rdw();
    test_transp();
    test_dim();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
